// File: rtl/egress_pri_scheduler.sv
// Egress priority scheduler: picks one of num_of_priority queues per decision,
// strict priority or weighted round robin, and holds off new decisions until
// the granted packet has been fully read.
//
// state | meaning
// IDLE  | no grant outstanding; evaluate eligible queues, or reload WRR credits
// GRANT | grant_vld asserted and held stable until grant_ack
// XFER  | grant accepted; waiting for the packet's last word (pkt_eop)
module egress_pri_scheduler #(
  parameter int num_of_priority = 8,
  parameter int priority_width  = 3,
  parameter int weight_width    = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sp0_wrr1,
  input  logic [num_of_priority-1:0]              q_nempty,
  input  logic [num_of_priority-1:0]              ready,
  input  logic [num_of_priority*weight_width-1:0] wrr_weight,
  input  logic                                    grant_ack,
  input  logic                                    pkt_eop,
  output logic                                    grant_vld,
  output logic [priority_width-1:0]               grant_pri,
  output logic                                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  logic [weight_width-1:0]     credit     [num_of_priority];
  logic [weight_width-1:0]     credit_nxt [num_of_priority];
  logic [priority_width-1:0]   rr_ptr, rr_ptr_nxt;
  logic [priority_width-1:0]   grant_pri_nxt;
  logic                        grant_vld_nxt, busy_nxt;
  // Mode under which the outstanding grant was issued; decides whether the
  // ack updates WRR bookkeeping, since sp0_wrr1 is only sampled in IDLE.
  logic                        wrr_mode, wrr_mode_nxt;

  logic [num_of_priority-1:0]  eligible, has_credit;
  logic                        wrr_found;
  logic [priority_width-1:0]   sp_idx, wrr_idx;
  logic [weight_width-1:0]     credit_dec;

  assign eligible = q_nempty & ready;

  // Candidate selection: highest eligible index for SP, first credited
  // eligible index scanning downward from rr_ptr for WRR.
  always_comb begin
    logic [priority_width-1:0] scan_idx;
    sp_idx    = '0;
    wrr_found = 1'b0;
    wrr_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < num_of_priority; i++) begin
      has_credit[i] = eligible[i] && (credit[i] != '0);
      if (eligible[i]) begin
        sp_idx = priority_width'(i);
      end
    end
    // Descending k so the last write, k=0 (rr_ptr itself), has top precedence.
    for (int k = num_of_priority - 1; k >= 0; k--) begin
      scan_idx = rr_ptr - priority_width'(k);
      if (has_credit[scan_idx]) begin
        wrr_found = 1'b1;
        wrr_idx   = scan_idx;
      end
    end
  end

  // Next-state, output and WRR bookkeeping decode.
  always_comb begin
    state_nxt     = state;
    grant_vld_nxt = grant_vld;
    grant_pri_nxt = grant_pri;
    busy_nxt      = busy;
    rr_ptr_nxt    = rr_ptr;
    wrr_mode_nxt  = wrr_mode;
    credit_nxt    = credit;
    credit_dec    = (credit[grant_pri] != '0) ? credit[grant_pri] - 1'b1 : '0;

    case (state)
      IDLE: begin
        if (eligible != '0) begin
          if (!sp0_wrr1) begin
            grant_pri_nxt = sp_idx;
            grant_vld_nxt = 1'b1;
            busy_nxt      = 1'b1;
            wrr_mode_nxt  = 1'b0;
            state_nxt     = GRANT;
          end else if (wrr_found) begin
            grant_pri_nxt = wrr_idx;
            grant_vld_nxt = 1'b1;
            busy_nxt      = 1'b1;
            wrr_mode_nxt  = 1'b1;
            state_nxt     = GRANT;
          end else begin
            // Credits exhausted for every eligible queue: one bubble to reload.
            // A zero weight still earns one packet per round.
            for (int i = 0; i < num_of_priority; i++) begin
              if (wrr_weight[i*weight_width +: weight_width] == '0) begin
                credit_nxt[i] = weight_width'(1);
              end else begin
                credit_nxt[i] = wrr_weight[i*weight_width +: weight_width];
              end
            end
          end
        end
      end
      GRANT: begin
        if (grant_ack) begin
          grant_vld_nxt = 1'b0;
          if (wrr_mode) begin
            credit_nxt[grant_pri] = credit_dec;
            rr_ptr_nxt = (credit_dec == '0) ? grant_pri - priority_width'(1) : grant_pri;
          end
          if (pkt_eop) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = XFER;
          end
        end
      end
      XFER: begin
        if (pkt_eop) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_vld_nxt = 1'b0;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State, output and credit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_vld <= 1'b0;
      grant_pri <= '0;
      busy      <= 1'b0;
      rr_ptr    <= priority_width'(num_of_priority - 1);
      wrr_mode  <= 1'b0;
      for (int i = 0; i < num_of_priority; i++) begin
        credit[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      grant_vld <= grant_vld_nxt;
      grant_pri <= grant_pri_nxt;
      busy      <= busy_nxt;
      rr_ptr    <= rr_ptr_nxt;
      wrr_mode  <= wrr_mode_nxt;
      credit    <= credit_nxt;
    end
  end

endmodule
